timer_bank: RTL and testbench

//  Memory-mapped bank of NUM_CH independent programmable timers on the 8-bit CPU data bus.

---
 rtl/timer_bank_if.sv | 13 +
 rtl/timer_bank.sv | 122 ++++++++++++
 tb/tb_timer_bank.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_bank_if.sv
// CPU byte bus for timer_bank. "do" is a reserved word, so read data is carried on dout.
// Handshake: no valid/ready; we/re are single-cycle strobes qualified by addr on the same clk edge.
interface timer_bank_if;
    logic [15:0] addr;
    logic        we;
    logic        re;
    logic [7:0]  di;
    logic [7:0]  dout;
    logic        irq;

    modport master (output addr, we, re, di, input dout, irq);
    modport slave  (input addr, we, re, di, output dout, irq);
endinterface

// File: rtl/timer_bank.sv
// Bank of NUM_CH programmable timers (reload, ctrl, read-to-clear status, restart) on an 8-bit CPU bus.
// Each channel fires when count >= reload, so a lowered reload never lets the counter run away.
module timer_bank #(
    parameter int          NUM_CH        = 4,
    parameter int          CNT_W         = 32,
    parameter logic [15:0] BASE_ADDR     = 16'hFF40,
    parameter logic [31:0] RESET_RELOAD  = 32'd4999999,
    parameter bit          CH0_AUTOSTART = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    timer_bank_if.slave  bus
);

    localparam int               NB      = CNT_W / 8;
    localparam logic [CNT_W-1:0] RLD_RST = RESET_RELOAD[CNT_W-1:0];

    logic [CNT_W-1:0]  reload_q [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] per_q;
    logic [NUM_CH-1:0] ie_q;
    logic [NUM_CH-1:0] trig_q;
    logic              irq_q;

    logic [16:0]       rel;
    logic              above;
    logic [2:0]        off;
    logic [NUM_CH-1:0] sel;
    logic [NUM_CH-1:0] tc;
    logic [NUM_CH-1:0] wr_ctrl;
    logic [NUM_CH-1:0] rd_stat;
    logic [NUM_CH-1:0] restart;
    logic [7:0]        rdata;
    logic [31:0]       rl32;

    // 17-bit difference keeps the top-of-range compare free of 16-bit wrap
    assign rel   = {1'b0, bus.addr} - {1'b0, BASE_ADDR};
    assign above = (bus.addr >= BASE_ADDR);
    assign off   = rel[2:0];

    always_comb begin
        sel     = '0;
        tc      = '0;
        wr_ctrl = '0;
        rd_stat = '0;
        restart = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel[i]     = above && (rel[16:3] == 14'(i));
            wr_ctrl[i] = bus.we && sel[i] && (off == 3'd4);
            rd_stat[i] = bus.re && sel[i] && (off == 3'd5);
            restart[i] = bus.we && sel[i] && (off == 3'd6) && bus.di[0];
            tc[i]      = en_q[i] && (count_q[i] >= reload_q[i]);
        end
    end

    always_comb begin
        rdata = '0;
        rl32  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel[i]) begin
                rl32 = 32'(reload_q[i]);
                case (off)
                    3'd0:    rdata = rl32[7:0];
                    3'd1:    rdata = rl32[15:8];
                    3'd2:    rdata = rl32[23:16];
                    3'd3:    rdata = rl32[31:24];
                    3'd4:    rdata = {5'b0, ie_q[i], per_q[i], en_q[i]};
                    3'd5:    rdata = {7'b0, trig_q[i]};
                    default: rdata = '0;
                endcase
            end
        end
    end

    assign bus.dout = rdata;
    assign bus.irq  = irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                reload_q[i] <= RLD_RST;
                count_q[i]  <= '0;
                trig_q[i]   <= 1'b0;
                en_q[i]     <= (i == 0) && CH0_AUTOSTART;
                per_q[i]    <= (i == 0) && CH0_AUTOSTART;
                ie_q[i]     <= 1'b0;
            end
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(trig_q & ie_q);
            for (int i = 0; i < NUM_CH; i++) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.we && sel[i] && (off == 3'(b)))
                        reload_q[i][8*b +: 8] <= bus.di;
                end

                // A CPU write to CTRL beats the one-shot self-disable on the same edge
                if (wr_ctrl[i]) begin
                    en_q[i]  <= bus.di[0];
                    per_q[i] <= bus.di[1];
                    ie_q[i]  <= bus.di[2];
                end else if (tc[i] && !restart[i] && !per_q[i]) begin
                    en_q[i] <= 1'b0;
                end

                if (restart[i])
                    count_q[i] <= '0;
                else if (en_q[i])
                    count_q[i] <= tc[i] ? '0 : count_q[i] + 1'b1;

                if (restart[i])
                    trig_q[i] <= 1'b0;
                else if (tc[i])
                    trig_q[i] <= 1'b1;
                else if (rd_stat[i])
                    trig_q[i] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed bench for timer_bank against a per-channel behavioural model.
module tb_timer_bank;

    localparam int          NUM_CH   = 4;
    localparam int          CNT_W    = 16;
    localparam logic [15:0] BASE     = 16'hFF40;
    localparam logic [31:0] RST_RLD  = 32'h0001_00C7;
    localparam int          RLD_MASK = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    timer_bank_if bus ();

    timer_bank #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .BASE_ADDR(BASE),
        .RESET_RELOAD(RST_RLD), .CH0_AUTOSTART(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_dout;
    logic       last_irq;

    int unsigned m_reload [NUM_CH];
    int unsigned m_cnt    [NUM_CH];
    bit          m_en     [NUM_CH];
    bit          m_per    [NUM_CH];
    bit          m_ie     [NUM_CH];
    bit          m_trig   [NUM_CH];
    bit          m_irq;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] a);
        int ia, ch, off;
        ia = int'(a);
        if (ia < int'(BASE) || ia >= int'(BASE) + 8*NUM_CH) return 8'h00;
        ch  = (ia - int'(BASE)) / 8;
        off = (ia - int'(BASE)) % 8;
        if (off < 4) return (off < CNT_W/8) ? 8'((m_reload[ch] >> (8*off)) & 255) : 8'h00;
        if (off == 4) return {5'b0, m_ie[ch], m_per[ch], m_en[ch]};
        if (off == 5) return {7'b0, m_trig[ch]};
        return 8'h00;
    endfunction

    function automatic void model_step(input bit r, input bit w, input bit rd,
                                       input logic [15:0] a, input logic [7:0] d);
        int  ia, ch_s, off;
        bit  hit, mine, rs, fire, irq_new;
        if (r) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_reload[c] = RST_RLD & RLD_MASK;
                m_cnt[c] = 0; m_trig[c] = 0; m_ie[c] = 0;
                m_en[c] = (c == 0); m_per[c] = (c == 0);
            end
            m_irq = 0;
            return;
        end
        irq_new = 0;
        for (int c = 0; c < NUM_CH; c++) irq_new |= m_trig[c] & m_ie[c];
        ia   = int'(a);
        hit  = (ia >= int'(BASE)) && (ia < int'(BASE) + 8*NUM_CH);
        ch_s = (ia - int'(BASE)) / 8;
        off  = (ia - int'(BASE)) % 8;
        for (int c = 0; c < NUM_CH; c++) begin
            mine = hit && (ch_s == c);
            rs   = w && mine && off == 6 && d[0];
            fire = m_en[c] && (m_cnt[c] >= m_reload[c]);
            if (rs) begin
                m_cnt[c] = 0; m_trig[c] = 0;
            end else begin
                if (m_en[c]) begin
                    if (fire) begin
                        m_cnt[c] = 0; m_trig[c] = 1;
                        if (!m_per[c]) m_en[c] = 0;
                    end else m_cnt[c]++;
                end
                if (!fire && rd && mine && off == 5) m_trig[c] = 0;
            end
            if (w && mine && off < CNT_W/8)
                m_reload[c] = (m_reload[c] & ~(32'hFF << (8*off))) | (32'(d) << (8*off));
            if (w && mine && off == 4) begin
                m_en[c] = d[0]; m_per[c] = d[1]; m_ie[c] = d[2];
            end
        end
        m_irq = irq_new;
    endfunction

    // One bus cycle: drive at negedge, sample mid-low phase, model follows the posedge
    task automatic cyc(input bit r, input bit w, input bit rd, input logic [15:0] a,
                       input logic [7:0] d, input bit chk);
        rst = r; bus.we = w; bus.re = rd; bus.addr = a; bus.di = d;
        #1;
        last_dout = bus.dout;
        last_irq  = bus.irq;
        if (chk) begin
            exp_q.push_back(model_read(a));
            check($sformatf("dout@%h", a), {24'b0, bus.dout}, {24'b0, exp_q.pop_front()});
            check("irq", {31'b0, bus.irq}, {31'b0, m_irq});
        end
        @(posedge clk);
        model_step(r, w, rd, a, d);
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, 1'b0, a, d, 1'b1);
    endtask

    task automatic rd_clr(input logic [15:0] a);
        cyc(1'b0, 1'b0, 1'b1, a, 8'h00, 1'b1);
    endtask

    task automatic peek(input logic [15:0] a);
        cyc(1'b0, 1'b0, 1'b0, a, 8'h00, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) peek(BASE + 16'($urandom_range(0, 8*NUM_CH - 1)));
    endtask

    initial begin
        int first_t;
        rst = 1'b1; bus.we = 1'b0; bus.re = 1'b0; bus.addr = BASE; bus.di = 8'h00;
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b0);

        // T1: channel 0 autostarts, first flag after reload+1 edges
        first_t = 0;
        for (int t = 0; t < 1000 && first_t == 0; t++) begin
            peek(BASE + 16'd5);
            if (last_dout[0]) first_t = t;
        end
        check("t1_first_trig", 32'(first_t), 32'd200);
        peek(BASE + 16'd13);
        check("t1_ch1_stat", {24'b0, last_dout}, 32'd0);

        // T2: ch1 periodic reload 3, read-clear coinciding with terminal count
        wr(BASE + 16'd8, 8'd3); wr(BASE + 16'd9, 8'd0); wr(BASE + 16'd12, 8'd3);
        for (int k = 0; k < 40; k++)
            cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), BASE + 16'd13, 8'h00, 1'b1);
        for (int k = 0; k < 20 && m_cnt[1] != 3; k++) rd_clr(BASE + 16'd13);
        rd_clr(BASE + 16'd13);
        peek(BASE + 16'd13);
        check("t2_coincide", {24'b0, last_dout}, 32'd1);

        // T3: ch2 one-shot reload 10
        wr(BASE + 16'd16, 8'd10); wr(BASE + 16'd17, 8'd0); wr(BASE + 16'd20, 8'd1);
        first_t = 0;
        for (int t = 0; t < 100 && first_t == 0; t++) begin
            peek(BASE + 16'd21);
            if (last_dout[0]) first_t = t;
        end
        check("t3_first_trig", 32'(first_t), 32'd11);
        peek(BASE + 16'd20);
        check("t3_ctrl", {24'b0, last_dout}, 32'd0);
        rd_clr(BASE + 16'd21);
        idle(30);
        peek(BASE + 16'd21);
        check("t3_no_refire", {24'b0, last_dout}, 32'd0);

        // T4: ch3 irq path, reload lowered below running count
        wr(BASE + 16'd24, 8'd100); wr(BASE + 16'd25, 8'd0); wr(BASE + 16'd28, 8'd7);
        for (int k = 0; k < 200 && m_cnt[3] != 50; k++) peek(BASE + 16'd29);
        wr(BASE + 16'd24, 8'd20);
        peek(BASE + 16'd29);
        check("t4_stat_pre", {24'b0, last_dout}, 32'd0);
        peek(BASE + 16'd29);
        check("t4_stat_set", {24'b0, last_dout}, 32'd1);
        check("t4_irq_lag", {31'b0, last_irq}, 32'd0);
        rd_clr(BASE + 16'd29);
        check("t4_irq_up", {31'b0, last_irq}, 32'd1);
        peek(BASE + 16'd29);
        check("t4_irq_hold", {31'b0, last_irq}, 32'd1);
        peek(BASE + 16'd29);
        check("t4_irq_down", {31'b0, last_irq}, 32'd0);
        wr(BASE + 16'd28, 8'd0);

        // T5: restart on terminal count, then reset mid-count
        for (int k = 0; k < 20 && m_cnt[1] != 3; k++) rd_clr(BASE + 16'd13);
        wr(BASE + 16'd14, 8'd1);
        peek(BASE + 16'd13);
        check("t5_restart_trig", {24'b0, last_dout}, 32'd0);
        idle(7);
        cyc(1'b1, 1'b0, 1'b0, BASE, 8'h00, 1'b1);
        peek(BASE + 16'd8);
        check("t5_rst_reload", {24'b0, last_dout}, 32'h0000_00C7);
        peek(BASE + 16'd4);
        check("t5_rst_ctrl0", {24'b0, last_dout}, 32'd3);

        // T6: upper reload bytes absent in a 16-bit build, unmapped reads
        wr(BASE + 16'd2, 8'hFF); wr(BASE + 16'd3, 8'hA5);
        peek(BASE + 16'd2);
        check("t6_byte2", {24'b0, last_dout}, 32'd0);
        peek(BASE + 16'd3);
        check("t6_byte3", {24'b0, last_dout}, 32'd0);
        peek(BASE + 16'(8*NUM_CH));
        check("t6_unmapped_hi", {24'b0, last_dout}, 32'd0);
        peek(BASE - 16'd1);
        check("t6_unmapped_lo", {24'b0, last_dout}, 32'd0);

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          o;
            a = BASE - 16'd2 + 16'($urandom_range(0, 8*NUM_CH + 3));
            o = (int'(a) - int'(BASE)) % 8;
            d = (o == 1) ? 8'($urandom_range(0, 1)) : 8'($urandom_range(0, 255));
            cyc(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 3) == 0), a, d, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
